uart_rx_op: RTL
===============

Name: uart_rx_op

Overview:
- Serial UART receiver; the consumer-side counterpart of the team's UART transmitter.
- Deserialises 8N1, or 8E1/8O1 when parity is enabled, from a 16x-oversampled line.
- Presents each received byte with a one-cycle valid pulse plus parity and framing error flags.
- Sits between the board RX pin and the command/loopback logic. Parity parameters match the transmitter's so a TX→RX loopback is frame-compatible.

Parameters:
- VERIFY_ON, 1'b0: 1 = a parity bit follows the 8 data bits.
- VERIFY_EVEN, 1'b0: 1 = even parity, 0 = odd parity. Ignored when VERIFY_ON = 0.
- OVERSAMPLE, 16: clk_en_i ticks per bit period. Must be even and ≥ 8.

Ports:
- clk_i  input  1  system clock
- resetn_i  input  1  reset, asynchronous, active-low
- clk_en_i  input  1  single-cycle tick at OVERSAMPLE × baud
- uart_rx_i  input  1  asynchronous serial line, idle high
- data_o  output  8  last received byte, LSB received first
- valid_o  output  1  one clk_i pulse per completed frame
- parity_err_o  output  1  qualified by valid_o; parity mismatch
- frame_err_o  output  1  qualified by valid_o; stop bit sampled low
- uart_busy_o  output  1  high from confirmed start bit until return to IDLE

Behaviour:
- Reset (asynchronous, while resetn_i = 0):
  - data_o = 8'h00; valid_o, parity_err_o, frame_err_o, uart_busy_o = 0.
  - Synchroniser flops = 1; state = IDLE; counters = 0.
  - Reset mid-frame aborts the frame with no valid_o.
- Input conditioning:
  - uart_rx_i passes through a 2-FF synchroniser clocked every clk_i.
  - A 3-deep sample shift register loads the synchronised line on each clk_en_i.
  - Bit value = majority of the 3 samples taken at ticks MID-1, MID, MID+1, where MID = OVERSAMPLE/2 - 1.
- Counters:
  - tick_cnt counts 0..OVERSAMPLE-1 and advances only on clk_en_i.
  - bit_cnt counts 0..7.
- States:
  - IDLE: on clk_en_i with synchronised line = 0 → START; tick_cnt = 0.
  - START: at tick MID+1, evaluate majority.
    - Majority 1: false start → IDLE, no output.
    - Majority 0: busy = 1. Continue to tick OVERSAMPLE-1, then → DATA, tick_cnt = 0.
  - DATA: at tick MID+1, shift the majority bit into the shift register, LSB first. At OVERSAMPLE-1, increment bit_cnt; after bit 7 → PARITY if VERIFY_ON, else → STOP.
  - PARITY: at tick MID+1, compute the error.
    - Even: error = ^{data, p} ≠ 0.
    - Odd: error = ^{data, p} ≠ 1.
    - At OVERSAMPLE-1 → STOP.
  - STOP: at tick MID+1, capture stop bit s and latch outputs:
    - data_o ← shift register; valid_o = 1 for exactly one clk_i (the cycle after that tick).
    - parity_err_o ← parity error (forced 0 if !VERIFY_ON); frame_err_o ← !s.
    - Then: s = 1 → IDLE; s = 0 → BREAK.
  - BREAK: wait until a clk_en_i samples the line = 1, then → IDLE.
- uart_busy_o deasserts on entry to IDLE.
- Timing:
  - Return to IDLE at mid-stop-bit allows back-to-back frames with no idle gap.
  - Latency from the start bit's falling edge to valid_o: 2 clk_i (sync) + (9 or 10) × OVERSAMPLE + MID + 2 ticks, ±1 tick of edge quantisation.
- Output holding:
  - data_o and the error flags hold their values until the next frame completes.
  - valid_o is never high on two consecutive clk_i cycles.
- clk_en_i low: the FSM and counters hold state, so the line-sample rate is set by clk_en_i alone.

Decomposition:
- Shared package uart_pkg:
  - Rx state encoding: IDLE, START, DATA, PARITY, STOP, BREAK as 3-bit localparams.
  - Default OVERSAMPLE.
  - Parity-compute function, reused by the transmitter.
- One sub-module, uart_rx_sampler: 2-FF synchroniser + 3-sample majority vote. Outputs rx_sync and bit_vote.

Test Plan (clk_en_i every 4 clk_i, OVERSAMPLE = 16):
- 8N1 byte 8'hA5, VERIFY_ON = 0 → one valid_o pulse, data_o = 8'hA5, both error flags 0, uart_busy_o high only across the frame.
- VERIFY_ON = 1, VERIFY_EVEN = 1, send 8'h03 with p = 0, then 8'h03 with p = 1 → parity_err_o = 0, then 1; data_o = 8'h03 both times. Repeat with VERIFY_EVEN = 0 → flags inverted.
- Stop bit driven 0 for byte 8'h55, line held low 3 bit times then high → frame_err_o = 1 with data_o = 8'h55; no second valid_o until the line returns high; next frame 8'h0F received cleanly.
- Glitch low for 5 ticks in IDLE → no valid_o, uart_busy_o stays 0, FSM back in IDLE.
- Back-to-back frames 8'h00, 8'hFF, 8'h81 with zero idle gap, plus a single-tick inverted glitch at tick MID of one data bit → three valid_o pulses with the correct bytes (majority vote rejects the glitch).
- Assert resetn_i during DATA bit 4 of 8'hC3 → all outputs 0 immediately, no valid_o. After release, a full frame 8'h3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: rx state encoding, default oversampling, parity helper.
// Used by both the receiver and the transmitter so framing stays compatible.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_t;

    // Parity bit a transmitter appends so that the frame has the requested parity.
    function automatic logic parity_bit(input logic [7:0] dat, input logic even_mode);
        return even_mode ? ^dat : ~^dat;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line conditioning: 2-FF synchroniser plus 3-sample majority vote.
// Latency: 2 clk_i to rx_sync; vote is combinational over the sample window.
// Backpressure: none, free-running; samples advance only on clk_en_i.
module uart_rx_sampler (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic clk_en_i,
    input  logic uart_rx_i,
    output logic rx_sync,
    output logic bit_vote
);

    logic       sync_meta;
    logic [1:0] samp;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            sync_meta <= 1'b1;
            rx_sync   <= 1'b1;
            samp      <= 2'b11;
        end else begin
            sync_meta <= uart_rx_i;
            rx_sync   <= sync_meta;
            if (clk_en_i) begin
                samp <= {samp[0], rx_sync};
            end
        end
    end

    // Window is the two previous ticks plus the sample being taken on this tick,
    // so a decision made at tick MID+1 covers ticks MID-1, MID, MID+1.
    assign bit_vote = (samp[1] & samp[0]) | (samp[1] & rx_sync) | (samp[0] & rx_sync);

endmodule

// File: rtl/uart_rx_op.sv
// UART receiver, 8N1 or 8E1/8O1, from a line oversampled by clk_en_i.
// Latency: 2 clk_i + (9|10)*OVERSAMPLE + MID + 2 ticks from start edge to valid_o.
// Backpressure: none; valid_o is a one-cycle pulse, data/flags hold until next frame.
module uart_rx_op
    import uart_pkg::*;
#(
    parameter logic VERIFY_ON   = 1'b0,
    parameter logic VERIFY_EVEN = 1'b0,
    parameter int   OVERSAMPLE  = UART_OVERSAMPLE
) (
    input  logic       clk_i,
    input  logic       resetn_i,
    input  logic       clk_en_i,
    input  logic       uart_rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       uart_busy_o
);

    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int MID = OVERSAMPLE / 2 - 1;

    rx_state_t       state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_err_q, par_err_d;
    logic            busy_d;
    logic [7:0]      data_d;
    logic            valid_d, perr_d, ferr_d;
    logic            rx_sync, bit_vote;
    logic            tick_mid, tick_last;

    uart_rx_sampler u_sampler (
        .clk_i     (clk_i),
        .resetn_i  (resetn_i),
        .clk_en_i  (clk_en_i),
        .uart_rx_i (uart_rx_i),
        .rx_sync   (rx_sync),
        .bit_vote  (bit_vote)
    );

    assign tick_mid  = (tick_q == TW'(MID + 1));
    assign tick_last = (tick_q == TW'(OVERSAMPLE - 1));

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q      <= RX_IDLE;
            tick_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            par_err_q    <= 1'b0;
            uart_busy_o  <= 1'b0;
            data_o       <= '0;
            valid_o      <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            par_err_q    <= par_err_d;
            uart_busy_o  <= busy_d;
            data_o       <= data_d;
            valid_o      <= valid_d;
            parity_err_o <= perr_d;
            frame_err_o  <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        busy_d    = uart_busy_o;
        data_d    = data_o;
        valid_d   = 1'b0;
        perr_d    = parity_err_o;
        ferr_d    = frame_err_o;

        if (clk_en_i) begin
            tick_d = tick_last ? '0 : tick_q + 1'b1;
            unique case (state_q)
                RX_IDLE: begin
                    tick_d = '0;
                    if (!rx_sync) begin
                        state_d = RX_START;
                    end
                end
                RX_START: begin
                    if (tick_mid && bit_vote) begin
                        state_d = RX_IDLE;
                        tick_d  = '0;
                    end else begin
                        if (tick_mid) begin
                            busy_d = 1'b1;
                        end
                        if (tick_last) begin
                            state_d = RX_DATA;
                            bit_d   = '0;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick_mid) begin
                        shift_d = {bit_vote, shift_q[7:1]};
                    end
                    if (tick_last) begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = VERIFY_ON ? RX_PARITY : RX_STOP;
                        end
                    end
                end
                RX_PARITY: begin
                    if (tick_mid) begin
                        par_err_d = (parity_bit(shift_q, VERIFY_EVEN) != bit_vote);
                    end
                    if (tick_last) begin
                        state_d = RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (tick_mid) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                        perr_d  = VERIFY_ON ? par_err_q : 1'b0;
                        ferr_d  = !bit_vote;
                        tick_d  = '0;
                        // Leaving at mid-stop lets the next start edge be caught with no gap.
                        if (bit_vote) begin
                            state_d = RX_IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = RX_BREAK;
                        end
                    end
                end
                RX_BREAK: begin
                    tick_d = '0;
                    if (rx_sync) begin
                        state_d = RX_IDLE;
                        busy_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = RX_IDLE;
                    tick_d  = '0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

endmodule
